// File: rtl/pipeline_control.sv
// Pipelined MIPS control: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles,
// load-use stall, branch/jump flush, memory back-pressure freeze and event counters.
module pipeline_control #(
   parameter int REG_W     = 5,
   parameter int ALUOP_W   = 4,
   parameter int LINK_REG  = 31,
   parameter int HAZARD_EN = 1,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [5:0]         id_opcode,
   input  logic [5:0]         id_func,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic [REG_W-1:0]   id_rd,
   input  logic               ex_take_branch,
   input  logic               mem_busy,
   output logic               pc_en,
   output logic               flush_ifid,
   output logic               id_jump,
   output logic               id_jump_r,
   output logic               id_illegal,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_alu_src,
   output logic               ex_branch,
   output logic               ex_branch_not,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic               ex_reg_write,
   output logic               ex_mem_to_reg,
   output logic               ex_byte,
   output logic               ex_jal,
   output logic [REG_W-1:0]   ex_dest,
   output logic               mem_mem_read,
   output logic               mem_mem_write,
   output logic               mem_reg_write,
   output logic               mem_mem_to_reg,
   output logic               mem_byte,
   output logic               mem_jal,
   output logic [REG_W-1:0]   mem_dest,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic               wb_jal,
   output logic [REG_W-1:0]   wb_dest,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
);

   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               branch;
      logic               branch_not;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
      logic               byte_op;
      logic               jal;
      logic [REG_W-1:0]   dest;
   } ex_bundle_t;

   typedef struct packed {
      logic             mem_read;
      logic             mem_write;
      logic             reg_write;
      logic             mem_to_reg;
      logic             byte_op;
      logic             jal;
      logic [REG_W-1:0] dest;
   } mem_bundle_t;

   typedef struct packed {
      logic             reg_write;
      logic             mem_to_reg;
      logic             jal;
      logic [REG_W-1:0] dest;
   } wb_bundle_t;

   ex_bundle_t  dec_s, id_bundle_s, ex_d, ex_q;
   mem_bundle_t mem_d, mem_q;
   wb_bundle_t  wb_d, wb_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
   logic jump_s, jump_r_s, illegal_s, reads_rt_s, hazard_s;
   logic pc_en_s, flush_s, stall_apply_s;

   // Opcode decode into an EX-stage control bundle
   always_comb begin
      dec_s      = '0;
      jump_s     = 1'b0;
      jump_r_s   = 1'b0;
      illegal_s  = 1'b0;
      reads_rt_s = 1'b0;
      case (id_opcode)
         6'd0: begin
            dec_s.dest = id_rd;
            reads_rt_s = 1'b1;
            if (id_func == 6'd8) begin
               dec_s.reg_write = 1'b0;
               jump_r_s        = 1'b1;
            end else begin
               dec_s.reg_write = 1'b1;
               jump_r_s        = 1'b0;
            end
         end
         6'd35, 6'd32: begin
            dec_s.mem_read   = 1'b1;
            dec_s.mem_to_reg = 1'b1;
            dec_s.alu_src    = 1'b1;
            dec_s.reg_write  = 1'b1;
            dec_s.dest       = id_rt;
            dec_s.alu_op     = ALUOP_W'(4'b0010);
            dec_s.byte_op    = (id_opcode == 6'd32);
         end
         6'd43: begin
            dec_s.mem_write = 1'b1;
            dec_s.alu_src   = 1'b1;
            dec_s.alu_op    = ALUOP_W'(4'b0010);
            reads_rt_s      = 1'b1;
         end
         6'd4: begin
            dec_s.branch = 1'b1;
            dec_s.alu_op = ALUOP_W'(4'b0110);
            reads_rt_s   = 1'b1;
         end
         6'd5: begin
            dec_s.branch_not = 1'b1;
            dec_s.alu_op     = ALUOP_W'(4'b0110);
            reads_rt_s       = 1'b1;
         end
         6'd2: jump_s = 1'b1;
         6'd3: begin
            jump_s          = 1'b1;
            dec_s.jal       = 1'b1;
            dec_s.reg_write = 1'b1;
            dec_s.dest      = REG_W'(LINK_REG);
         end
         6'd8, 6'd12, 6'd13, 6'd14, 6'd10, 6'd15: begin
            dec_s.alu_src   = 1'b1;
            dec_s.reg_write = 1'b1;
            dec_s.dest      = id_rt;
            case (id_opcode)
               6'd8:    dec_s.alu_op = ALUOP_W'(4'b0010);
               6'd13:   dec_s.alu_op = ALUOP_W'(4'b0001);
               6'd14:   dec_s.alu_op = ALUOP_W'(4'b1101);
               6'd10:   dec_s.alu_op = ALUOP_W'(4'b0111);
               6'd15:   dec_s.alu_op = ALUOP_W'(4'b1110);
               default: dec_s.alu_op = ALUOP_W'(4'b0000);
            endcase
         end
         default: illegal_s = 1'b1;
      endcase
   end

   // r0 is never a real write target
   always_comb begin
      id_bundle_s           = dec_s;
      id_bundle_s.reg_write = dec_s.reg_write && (dec_s.dest != '0);
   end

   assign id_jump    = id_valid && jump_s;
   assign id_jump_r  = id_valid && jump_r_s;
   assign id_illegal = id_valid && illegal_s;

   assign hazard_s = (HAZARD_EN != 0) && id_valid && ex_q.mem_read && (ex_q.dest != '0) &&
                     ((ex_q.dest == id_rs) || (reads_rt_s && (ex_q.dest == id_rt)));

   // Priority: mem_busy freeze, then taken-branch flush, then load-use stall, then normal issue
   always_comb begin
      pc_en_s       = 1'b1;
      flush_s       = 1'b0;
      stall_apply_s = 1'b0;
      ex_d          = ex_q;
      mem_d         = mem_q;
      wb_d          = wb_q;
      if (mem_busy) begin
         pc_en_s = 1'b0;
      end else begin
         mem_d.mem_read   = ex_q.mem_read;
         mem_d.mem_write  = ex_q.mem_write;
         mem_d.reg_write  = ex_q.reg_write;
         mem_d.mem_to_reg = ex_q.mem_to_reg;
         mem_d.byte_op    = ex_q.byte_op;
         mem_d.jal        = ex_q.jal;
         mem_d.dest       = ex_q.dest;
         wb_d.reg_write   = mem_q.reg_write;
         wb_d.mem_to_reg  = mem_q.mem_to_reg;
         wb_d.jal         = mem_q.jal;
         wb_d.dest        = mem_q.dest;
         if (ex_take_branch) begin
            flush_s = 1'b1;
            ex_d    = '0;
         end else if (hazard_s) begin
            pc_en_s       = 1'b0;
            stall_apply_s = 1'b1;
            ex_d          = '0;
         end else begin
            flush_s = id_jump || id_jump_r;
            ex_d    = (id_valid && !illegal_s) ? id_bundle_s : '0;
         end
      end
   end

   // Saturating event counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_apply_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Stage registers and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_en          = pc_en_s;
   assign flush_ifid     = flush_s;
   assign ex_alu_op      = ex_q.alu_op;
   assign ex_alu_src     = ex_q.alu_src;
   assign ex_branch      = ex_q.branch;
   assign ex_branch_not  = ex_q.branch_not;
   assign ex_mem_read    = ex_q.mem_read;
   assign ex_mem_write   = ex_q.mem_write;
   assign ex_reg_write   = ex_q.reg_write;
   assign ex_mem_to_reg  = ex_q.mem_to_reg;
   assign ex_byte        = ex_q.byte_op;
   assign ex_jal         = ex_q.jal;
   assign ex_dest        = ex_q.dest;
   assign mem_mem_read   = mem_q.mem_read;
   assign mem_mem_write  = mem_q.mem_write;
   assign mem_reg_write  = mem_q.reg_write;
   assign mem_mem_to_reg = mem_q.mem_to_reg;
   assign mem_byte       = mem_q.byte_op;
   assign mem_jal        = mem_q.jal;
   assign mem_dest       = mem_q.dest;
   assign wb_reg_write   = wb_q.reg_write;
   assign wb_mem_to_reg  = wb_q.mem_to_reg;
   assign wb_jal         = wb_q.jal;
   assign wb_dest        = wb_q.dest;
   assign stall_count    = stall_cnt_q;
   assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed table-driven bench for pipeline_control plus hand sequences for
// mem_busy freeze and reset asserted in the middle of a stall.
module tb_pipeline_control;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, ex_take_branch, mem_busy;
   logic [5:0]  id_opcode, id_func;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        pc_en, flush_ifid, id_jump, id_jump_r, id_illegal;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src, ex_branch, ex_branch_not, ex_mem_read, ex_mem_write;
   logic        ex_reg_write, ex_mem_to_reg, ex_byte, ex_jal;
   logic [4:0]  ex_dest, mem_dest, wb_dest;
   logic        mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_byte, mem_jal;
   logic        wb_reg_write, wb_mem_to_reg, wb_jal;
   logic [15:0] stall_count, flush_count;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_control dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_func(id_func),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_take_branch(ex_take_branch),
      .mem_busy(mem_busy), .pc_en(pc_en), .flush_ifid(flush_ifid), .id_jump(id_jump),
      .id_jump_r(id_jump_r), .id_illegal(id_illegal), .ex_alu_op(ex_alu_op),
      .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_branch_not(ex_branch_not),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_byte(ex_byte), .ex_jal(ex_jal), .ex_dest(ex_dest),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
      .mem_mem_to_reg(mem_mem_to_reg), .mem_byte(mem_byte), .mem_jal(mem_jal),
      .mem_dest(mem_dest), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_jal(wb_jal), .wb_dest(wb_dest), .stall_count(stall_count), .flush_count(flush_count)
   );

   typedef struct {
      logic       v;
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd;
      logic       br;
      logic       pc, fl, jp, jr, il;
      logic [3:0] alu;
      logic       rw, mr;
      logic [4:0] dst;
      logic       wrw;
      logic [4:0] wdst;
      int         sc, fc;
   } vec_t;

   vec_t tbl[19];

   function automatic vec_t mk(input logic v, input int op, input int fn, input int rs,
                               input int rt, input int rd, input logic br, input logic pc,
                               input logic fl, input logic jp, input logic jr, input logic il,
                               input int alu, input logic rw, input logic mr, input int dst,
                               input logic wrw, input int wdst, input int sc, input int fc);
      vec_t r;
      r.v = v; r.op = 6'(op); r.fn = 6'(fn); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
      r.br = br; r.pc = pc; r.fl = fl; r.jp = jp; r.jr = jr; r.il = il;
      r.alu = 4'(alu); r.rw = rw; r.mr = mr; r.dst = 5'(dst);
      r.wrw = wrw; r.wdst = 5'(wdst); r.sc = sc; r.fc = fc;
      return r;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic v, input int op, input int fn, input int rs, input int rt,
                        input int rd, input logic br, input logic busy);
      id_valid = v; id_opcode = 6'(op); id_func = 6'(fn);
      id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
      ex_take_branch = br; mem_busy = busy;
   endtask

   initial begin
      //                v op fn rs rt rd br pc fl jp jr il alu rw mr dst wrw wdst sc fc
      tbl[0]  = mk(1, 8, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 3, 0, 0, 0, 0);  // addi r3
      tbl[1]  = mk(1, 0,32, 1, 2, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0);  // add r4
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);  // invalid
      tbl[3]  = mk(1,35, 0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 5, 1, 4, 0, 0);  // lw r5
      tbl[4]  = mk(1, 0,32, 5, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // add rs=r5 stall
      tbl[5]  = mk(1, 0,32, 5, 2, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0, 6, 1, 5, 1, 0);  // add retried
      tbl[6]  = mk(1,35, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 1, 0);  // lw r0
      tbl[7]  = mk(1, 0,32, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1, 0, 7, 1, 6, 1, 0);  // use r0: no stall
      tbl[8]  = mk(1,35, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 8, 0, 0, 1, 0);  // lw r8
      tbl[9]  = mk(1, 0,32, 8, 2, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 1);  // hazard + branch
      tbl[10] = mk(1, 4, 0, 2, 3, 0, 0, 1, 0, 0, 0, 0, 6, 0, 0, 0, 1, 8, 1, 1);  // beq
      tbl[11] = mk(1, 2, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);  // j
      tbl[12] = mk(1, 0, 8,31, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3);  // jr
      tbl[13] = mk(1,63, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3);  // illegal
      tbl[14] = mk(1,13, 0, 1,10, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0,10, 0, 0, 1, 3);  // ori r10
      tbl[15] = mk(1,43, 0, 1,10, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 3);  // sw
      tbl[16] = mk(1,35, 0, 1,11, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1,11, 1,10, 1, 3);  // lw r11
      tbl[17] = mk(1,43, 0, 1,11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3);  // sw rt=r11 stall
      tbl[18] = mk(1,43, 0, 1,11, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 1,11, 2, 3);  // sw retried

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_pc_en", 0, 32'(pc_en), 32'd1);
      chk("rst_ex_dest", 0, 32'(ex_dest), 32'd0);
      chk("rst_wb_dest", 0, 32'(wb_dest), 32'd0);
      chk("rst_counts", 0, {stall_count, flush_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].op, tbl[i].fn, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].br, 1'b0);
         #1;
         chk("pc_en", i, 32'(pc_en), 32'(tbl[i].pc));
         chk("flush_ifid", i, 32'(flush_ifid), 32'(tbl[i].fl));
         chk("id_jump", i, 32'(id_jump), 32'(tbl[i].jp));
         chk("id_jump_r", i, 32'(id_jump_r), 32'(tbl[i].jr));
         chk("id_illegal", i, 32'(id_illegal), 32'(tbl[i].il));
         @(posedge clk);
         #1;
         chk("ex_alu_op", i, 32'(ex_alu_op), 32'(tbl[i].alu));
         chk("ex_reg_write", i, 32'(ex_reg_write), 32'(tbl[i].rw));
         chk("ex_mem_read", i, 32'(ex_mem_read), 32'(tbl[i].mr));
         chk("ex_dest", i, 32'(ex_dest), 32'(tbl[i].dst));
         chk("wb_reg_write", i, 32'(wb_reg_write), 32'(tbl[i].wrw));
         chk("wb_dest", i, 32'(wb_dest), 32'(tbl[i].wdst));
         chk("stall_count", i, 32'(stall_count), 32'(tbl[i].sc));
         chk("flush_count", i, 32'(flush_count), 32'(tbl[i].fc));
      end

      // jal frozen two cycles in MEM by mem_busy
      @(negedge clk);
      drive(1, 3, 0, 0, 0, 0, 0, 0);
      #1;
      chk("jal_flush", 0, 32'(flush_ifid), 32'd1);
      @(posedge clk); #1;
      chk("jal_ex", 0, {ex_jal, ex_reg_write, 3'(0), ex_dest}, {1'b1, 1'b1, 3'(0), 5'd31});
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("jal_mem", 0, {mem_jal, mem_dest}, {1'b1, 5'd31});
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(1, 8, 0, 1, 12, 0, 1, 1);
         #1;
         chk("busy_pc_en", k, 32'(pc_en), 32'd0);
         chk("busy_flush", k, 32'(flush_ifid), 32'd0);
         @(posedge clk); #1;
         chk("busy_mem_hold", k, {mem_jal, mem_reg_write, mem_dest}, {1'b1, 1'b1, 5'd31});
         chk("busy_ex_hold", k, {ex_reg_write, ex_dest}, 6'd0);
         chk("busy_wb_hold", k, {wb_jal, wb_dest}, 6'd0);
         chk("busy_flush_cnt", k, 32'(flush_count), 32'd4);
      end
      @(negedge clk);
      drive(1, 8, 0, 1, 12, 0, 0, 0);
      @(posedge clk); #1;
      chk("jal_wb_late", 0, {wb_jal, wb_reg_write, wb_dest}, {1'b1, 1'b1, 5'd31});
      chk("addi_after_busy", 0, {ex_alu_op, ex_dest}, {4'b0010, 5'd12});

      // illegal opcode, then reset in the middle of a load-use stall
      @(negedge clk);
      drive(1, 63, 0, 0, 0, 0, 0, 0);
      #1;
      chk("op63_illegal", 0, 32'(id_illegal), 32'd1);
      @(posedge clk); #1;
      chk("op63_bubble", 0, {ex_alu_op, ex_reg_write, ex_alu_src, ex_dest}, 11'd0);
      @(negedge clk);
      drive(1, 35, 0, 1, 13, 0, 0, 0);
      @(negedge clk);
      drive(1, 0, 32, 13, 2, 14, 0, 0);
      #1;
      chk("pre_rst_stall", 0, 32'(pc_en), 32'd0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_pc_en", 1, 32'(pc_en), 32'd1);
      chk("rst_ex", 1, {ex_mem_read, ex_reg_write, ex_dest}, 7'd0);
      chk("rst_mem_wb", 1, {mem_reg_write, mem_jal, mem_dest, wb_reg_write, wb_jal, wb_dest}, 14'd0);
      chk("rst_counts", 1, {stall_count, flush_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_pc_en", 0, 32'(pc_en), 32'd1);
      @(posedge clk); #1;
      chk("post_rst_add", 0, {ex_reg_write, ex_dest}, {1'b1, 5'd14});
      chk("post_rst_stall_cnt", 0, 32'(stall_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
